// File: rtl/amult_pipe.sv
// Three-stage, multi-lane approximate shift-add multiplier: operand times an
// unsigned fractional coefficient, summed as arithmetic right-shift terms.
module amult_pipe #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 16,
  parameter int LANES = 4,
  parameter int GROUP = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [LANES*WIDTH-1:0]       DAT_IN,
  input  logic [LANES*SHIFT-1:0]       SHIFT_VAL,
  input  logic [$clog2(SHIFT+1)-1:0]   TERM_CNT,
  input  logic                         RND,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [LANES*WIDTH-1:0]       DAT_OUT
);
  localparam int NGRP = (SHIFT + GROUP - 1) / GROUP;
  localparam int SW   = WIDTH + 1;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // Every stage advances together on en; IN_READY is en, so input acceptance and
  // output consumption in one cycle simply shift the whole pipe by one slot.
  logic                                  en;
  logic [SHIFT-1:0]                      mask;

  logic                                  s1_valid_q, s1_valid_d;
  logic [LANES*WIDTH-1:0]                s1_dat_q, s1_dat_d;
  logic [LANES*SHIFT-1:0]                s1_coef_q, s1_coef_d;
  logic                                  s1_rnd_q, s1_rnd_d;

  logic                                  s2_valid_q, s2_valid_d;
  logic [LANES-1:0][NGRP-1:0][WIDTH-1:0] s2_grp_q, s2_grp_d;

  logic                                  out_valid_q, out_valid_d;
  logic [LANES*WIDTH-1:0]                out_dat_q, out_dat_d;

  logic signed [SW-1:0]                  ext;
  logic signed [SW-1:0]                  biased;
  logic signed [WIDTH-1:0]               acc;
  logic [WIDTH-1:0]                      lane_sum;
  int                                    k;

  assign en        = ~out_valid_q | OUT_READY;
  assign IN_READY  = en;
  assign OUT_VALID = out_valid_q;
  assign DAT_OUT   = out_dat_q;

  // Stage 1 inputs: coefficient bit SHIFT-k survives only when k <= TERM_CNT.
  always_comb begin
    mask = '0;
    for (int j = 0; j < SHIFT; j++) begin
      mask[j] = (32'(TERM_CNT) >= 32'(SHIFT - j));
    end
    s1_valid_d = IN_VALID;
    s1_dat_d   = DAT_IN;
    s1_coef_d  = SHIFT_VAL & {LANES{mask}};
    s1_rnd_d   = RND;
  end

  // Stage 2: terms are formed in WIDTH+1 bits so the rounding bias never wraps;
  // every term and partial sum shares the operand's sign and stays below |x|,
  // so group sums fit in WIDTH bits.
  always_comb begin
    s2_grp_d   = '0;
    s2_valid_d = s1_valid_q;
    ext        = '0;
    biased     = '0;
    acc        = '0;
    k          = 0;
    for (int l = 0; l < LANES; l++) begin
      ext = {s1_dat_q[l*WIDTH+WIDTH-1], s1_dat_q[l*WIDTH +: WIDTH]};
      for (int g = 0; g < NGRP; g++) begin
        acc = '0;
        for (int t = 0; t < GROUP; t++) begin
          k = g * GROUP + t + 1;
          if (k <= SHIFT) begin
            biased = ext + (s1_rnd_q ? (SW'(1) << (k - 1)) : SW'(0));
            if (s1_coef_q[l*SHIFT + SHIFT - k]) begin
              acc = acc + WIDTH'(biased >>> k);
            end
          end
        end
        s2_grp_d[l][g] = acc;
      end
    end
  end

  // Stage 3: fold the group sums of each lane into the output register.
  always_comb begin
    out_dat_d   = '0;
    out_valid_d = s2_valid_q;
    lane_sum    = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = '0;
      for (int g = 0; g < NGRP; g++) begin
        lane_sum = lane_sum + s2_grp_q[l][g];
      end
      out_dat_d[l*WIDTH +: WIDTH] = lane_sum;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      s1_dat_q    <= '0;
      s1_coef_q   <= '0;
      s1_rnd_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_grp_q    <= '0;
      out_valid_q <= 1'b0;
      out_dat_q   <= '0;
    end else if (en) begin
      s1_valid_q  <= s1_valid_d;
      s1_dat_q    <= s1_dat_d;
      s1_coef_q   <= s1_coef_d;
      s1_rnd_q    <= s1_rnd_d;
      s2_valid_q  <= s2_valid_d;
      s2_grp_q    <= s2_grp_d;
      out_valid_q <= out_valid_d;
      out_dat_q   <= out_dat_d;
    end
  end

endmodule

// File: tb/tb_amult_pipe.sv
// Self-checking bench for amult_pipe: scoreboard queue filled by the driver,
// drained by an independent output monitor, against a 64-bit arithmetic model.
module tb_amult_pipe;
  localparam int WIDTH = 32;
  localparam int SHIFT = 16;
  localparam int LANES = 4;
  localparam int GROUP = 4;
  localparam int CW    = $clog2(SHIFT + 1);
  localparam int DW    = LANES * WIDTH;
  localparam int KW    = LANES * SHIFT;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [DW-1:0] DAT_IN = '0;
  logic [KW-1:0] SHIFT_VAL = '0;
  logic [CW-1:0] TERM_CNT = '0;
  logic          RND = 1'b0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;
  logic [DW-1:0] DAT_OUT;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            rand_done = 1'b0;
  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  bit            exact_q[$];

  amult_pipe #(.WIDTH(WIDTH), .SHIFT(SHIFT), .LANES(LANES), .GROUP(GROUP)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DAT_IN(DAT_IN), .SHIFT_VAL(SHIFT_VAL), .TERM_CNT(TERM_CNT), .RND(RND),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DAT_OUT(DAT_OUT)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference: product as a sum of floor-divided terms in 64-bit integers.
  function automatic logic [WIDTH-1:0] ref_lane(input logic [WIDTH-1:0] x,
                                                input logic [SHIFT-1:0] c,
                                                input int tc, input bit r);
    longint xs;
    longint sum;
    longint t;
    int     n;
    xs  = longint'($signed(x));
    sum = 0;
    n   = (tc > SHIFT) ? SHIFT : tc;
    for (int kk = 1; kk <= n; kk++) begin
      if (c[SHIFT-kk]) begin
        if (r) t = (xs + (longint'(1) << (kk - 1))) >>> kk;
        else   t = xs >>> kk;
        sum += t;
      end
    end
    return sum[WIDTH-1:0];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [DW-1:0] rand_dat();
    logic [DW-1:0] d;
    for (int l = 0; l < LANES; l++) begin
      case ($urandom_range(0, 7))
        0:       d[l*WIDTH +: WIDTH] = 32'h7FFF_FFFF;
        1:       d[l*WIDTH +: WIDTH] = 32'h8000_0000;
        default: d[l*WIDTH +: WIDTH] = $urandom();
      endcase
    end
    return d;
  endfunction

  function automatic logic [KW-1:0] rand_coef();
    logic [KW-1:0] c;
    for (int l = 0; l < LANES; l++) c[l*SHIFT +: SHIFT] = SHIFT'($urandom());
    return c;
  endfunction

  // Driver: holds a transaction until accepted, then pushes the expectation.
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] c,
                      input logic [CW-1:0] tc, input bit r, input bit exact,
                      input bit ov0, input logic [WIDTH-1:0] e0);
    logic [DW-1:0] e;
    bit            accepted;
    for (int l = 0; l < LANES; l++)
      e[l*WIDTH +: WIDTH] = ref_lane(d[l*WIDTH +: WIDTH], c[l*SHIFT +: SHIFT], int'(tc), r);
    if (ov0) e[WIDTH-1:0] = e0;
    DAT_IN    = d;
    SHIFT_VAL = c;
    TERM_CNT  = tc;
    RND       = r;
    IN_VALID  = 1'b1;
    accepted  = 1'b0;
    for (int g = 0; g < 200 && !accepted; g++) begin
      @(negedge CLK);
      if (IN_READY) accepted = 1'b1;
    end
    checks++;
    if (accepted) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      exact_q.push_back(exact);
    end else begin
      errors++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // Monitor / scoreboard: compares the head whenever a result is presented.
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (!RST && OUT_VALID) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got %h want none", DAT_OUT);
        end else begin
          check("dat_out", DAT_OUT, exp_q[0]);
          if (OUT_READY) begin
            if (exact_q[0]) check("latency", DW'(cyc - acc_q[0]), DW'(3));
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            void'(exact_q.pop_front());
          end
        end
      end
    end
  end

  logic [31:0]   d_t[10]  = '{32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                              32'h0000_0003, 32'h0000_0003, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000};
  logic [15:0]   c_t[10]  = '{16'hC000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                              16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
  logic [CW-1:0] tc_t[10] = '{5'd16, 5'd16, 5'd8, 5'd0, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd31};
  bit            r_t[10]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
  logic [31:0]   e_t[10]  = '{32'h0000_C000, 32'hFFFF_8000, 32'h0000_FF00, 32'h0000_0000, 32'h0000_FFFF,
                              32'h0000_0001, 32'h0000_0002, 32'h7FFF_8000, 32'h8000_8000, 32'h0000_FFFF};

  initial begin : main
    logic [DW-1:0] d;
    logic [KW-1:0] c;
    logic [DW-1:0] held;

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_out_valid", DW'(OUT_VALID), DW'(0));
    check("reset_dat_out", DAT_OUT, '0);
    check("reset_in_ready", DW'(IN_READY), DW'(1));
    @(posedge CLK); #1;

    // directed lane-0 cases, back to back, other lanes random
    for (int i = 0; i < 10; i++) begin
      d = rand_dat();
      c = rand_coef();
      d[WIDTH-1:0] = d_t[i];
      c[SHIFT-1:0] = c_t[i];
      send(d, c, tc_t[i], r_t[i], 1'b1, 1'b1, e_t[i]);
    end
    drain();

    // 10-transaction stream at full rate
    for (int i = 0; i < 10; i++)
      send(rand_dat(), rand_coef(), CW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, '0);
    drain();

    // stall with three in flight
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++)
      send(rand_dat(), rand_coef(), 5'd16, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
    held = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_in_ready", DW'(IN_READY), DW'(0));
      check("stall_out_valid", DW'(OUT_VALID), DW'(1));
      check("stall_dat_out", DAT_OUT, held);
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("release_out_valid", DW'(OUT_VALID), DW'(1));
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check("release_empty", DW'(OUT_VALID), DW'(0));
    @(posedge CLK); #1;
    drain();

    // reset with three in flight
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++)
      send(rand_dat(), rand_coef(), 5'd16, 1'b0, 1'b0, 1'b0, '0);
    RST = 1'b1;
    exp_q.delete();
    acc_q.delete();
    exact_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("flush_out_valid", DW'(OUT_VALID), DW'(0));
    check("flush_dat_out", DAT_OUT, '0);
    check("flush_in_ready", DW'(IN_READY), DW'(1));
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    repeat (6) begin
      @(posedge CLK); #1;
    end
    send(rand_dat(), rand_coef(), 5'd12, 1'b1, 1'b1, 1'b0, '0);
    drain();

    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(rand_dat(), rand_coef(), CW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'b0, 1'b0, '0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          OUT_READY = ($urandom_range(0, 3) != 0);
          @(posedge CLK); #1;
        end
        OUT_READY = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
